// File: rtl/imem_fetch_sync.sv
// Synchronous instruction memory with a valid/ready fetch port, a program-load port and a
// hardware clear sequence after reset. Define IMEM_STATS_EN to add fetch/error counters.
module imem_fetch_sync #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 64,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [XLEN-1:0]          rsp_instr,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [XLEN-1:0]          prog_data,
`ifdef IMEM_STATS_EN
    output logic [31:0]              fetch_cnt,
    output logic [15:0]              err_cnt,
`endif
    output logic                     prog_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_instr_q;
    logic            rsp_err_q;

    logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

    logic            accept;
    logic [XLEN-1:0] word_idx;
    logic            fetch_err;

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rsp_valid_d = rsp_valid_q;
        word_idx    = req_addr >> 2;
        // Full-width compare: any set bit above the index is out of range, never a wrap.
        fetch_err   = (req_addr[1:0] != 2'b00) || (word_idx >= XLEN'(DEPTH));
        req_ready   = (state_q == StRun) && !prog_we && (!rsp_valid_q || rsp_ready);
        accept      = req_valid && req_ready;
        prog_ready  = (state_q == StRun);
        init_done   = (state_q == StRun);

        unique case (state_q)
            StClear: begin
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = StRun;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            StRun: state_d = StRun;
            default: state_d = StClear;
        endcase

        // A same-cycle accept wins over flush/consume; only the older response is dropped.
        if (accept) begin
            rsp_valid_d = 1'b1;
        end else if (flush || rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StClear;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                rsp_err_q   <= fetch_err;
                rsp_instr_q <= fetch_err ? NOP_INSTR : mem[word_idx[AW-1:0]];
            end
        end
    end

    // Memory has no reset of its own; the clear sequence zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_idx_q] <= '0;
        end else if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_err   = rsp_err_q;

`ifdef IMEM_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (accept) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (fetch_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/imem_fetch_sync.md
Name: imem_fetch_sync

Overview:
Parametrised synchronous instruction memory for the next-generation RISC-V core. It replaces the combinational ROM-style fetch with a registered, valid/ready fetch port. It adds a word-indexed program-load write port, a hardware clear sequence after reset, misaligned/out-of-range fetch detection, and a flush for PC redirects. It sits between the PC/fetch stage and the decode stage.

Parameters:
XLEN, 32, address and instruction width in bits
DEPTH, 64, memory depth in words; power of 2, minimum 4
NOP_INSTR, 32'h00000013, instruction returned on an erroneous fetch (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
init_done  out  1  high once the clear sequence has finished
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request can be accepted this cycle
req_addr  in  XLEN  byte address of the fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  decode accepts the response
rsp_instr  out  XLEN  fetched instruction
rsp_err  out  1  fetch was misaligned or out of range
flush  in  1  discard the pending response (branch/jump redirect)
prog_we  in  1  program-load write strobe
prog_addr  in  $clog2(DEPTH)  program-load word index
prog_data  in  XLEN  program-load write data
prog_ready  out  1  program-load write is accepted this cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to CLEAR; clear index goes to 0.
  - Outputs: rsp_valid=0, rsp_instr=0, rsp_err=0, init_done=0.
  - Any in-flight response is dropped.
  - Reset asserted mid-CLEAR or mid-RUN restarts the clear from index 0.
- FSM states:
  - CLEAR: writes 0 to mem[idx] each cycle and increments idx. After the write to index DEPTH-1 it moves to RUN, so the clear takes exactly DEPTH cycles. In CLEAR: req_ready=0, prog_ready=0, init_done=0; prog_we and req_valid are ignored.
  - RUN: init_done=1 and stays 1 until the next reset. The FSM never leaves RUN except on reset.
- Program load (RUN only):
  - prog_ready=1 in RUN.
  - prog_we=1 writes mem[prog_addr] <= prog_data at the edge.
  - While prog_we=1, req_ready=0, so no fetch is accepted that cycle and read-during-write cannot occur.
- Fetch handshake:
  - req_ready = (state==RUN) && !prog_we && (!rsp_valid || rsp_ready).
  - A request is accepted when req_valid && req_ready. Latency is 1: the response is registered and appears the cycle after acceptance.
  - Accepted word index = req_addr >> 2.
  - rsp_err=1 when req_addr[1:0] != 0 or (req_addr >> 2) >= DEPTH. On error rsp_instr=NOP_INSTR and memory is not indexed.
  - Otherwise rsp_instr = mem[req_addr>>2] and rsp_err=0.
  - Address bits above the index are compared in full XLEN width. There is no wrap-around; out of range means error.
  - While rsp_valid && !rsp_ready: rsp_instr and rsp_err hold stable and req_ready=0 (stall).
  - rsp_valid && rsp_ready with no new accept: rsp_valid clears next cycle.
  - Back-to-back: consume and accept in the same cycle gives continuous one-per-cycle throughput.
- Flush:
  - flush=1 clears rsp_valid at the edge.
  - Accepting a request in the same cycle is allowed. The new request's response is kept (rsp_valid=1 next cycle); only the older response is discarded.
  - flush with no pending response has no effect.
- Memory contents:
  - Retained across nothing: every reset zeroes them via CLEAR.
  - Contents are initialised to 0 at time zero for simulation.

Optional Feature:
Macro: IMEM_STATS_EN
- Defined:
  - Adds outputs fetch_cnt (32b) and err_cnt (16b), both reset to 0 on rst.
  - fetch_cnt increments on every accepted request.
  - err_cnt increments on every accepted request flagged rsp_err; it saturates at 16'hFFFF.
  - Flushed responses are still counted.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Clear sequence, DEPTH=64: rst for 1 cycle, then release -> init_done=0 and req_ready=0 for exactly 64 cycles, init_done=1 on cycle 65. A fetch of addr 0x10 returns 32'h00000000 with rsp_err=0.
- Load and fetch: write prog_addr 1 = 32'h123450b7 and prog_addr 2 = 32'h12345117. During those writes req_ready=0. Then fetch 0x4 and 0x8 back-to-back with rsp_ready=1 -> rsp_instr 32'h123450b7 then 32'h12345117 on consecutive cycles, rsp_err=0.
- Errors: fetch 0x6 -> rsp_err=1, rsp_instr=32'h00000013. Fetch 0x100 (DEPTH=64) -> rsp_err=1, rsp_instr=32'h00000013.
- Stall: hold rsp_ready=0 for 3 cycles after a fetch of 0x4 -> rsp_instr stable at 32'h123450b7, req_ready=0 for those 3 cycles. Release -> next request accepted in the same cycle.
- Flush: pending response for 0x4 plus flush=1 and a new accept of 0x8 in the same cycle -> next cycle rsp_instr=32'h12345117 with rsp_valid=1. Flush with no accept -> rsp_valid=0.
- Reset mid-run: assert rst while rsp_valid=1 -> rsp_valid=0, init_done=0, a new 64-cycle clear runs, and previously loaded words read back 0. With IMEM_STATS_EN defined, fetch_cnt and err_cnt read 0.
